stream_select_arbiter: RTL and testbench
========================================

Name: stream_select_arbiter

Overview:
Generates the select token stream consumed by the data multiplexer stage. It watches the valid lines of the NUM_STREAMS input streams and grants one stream at a time, using rotating priority with a bounded packet burst per grant. Each grant is held stable on select_data until the multiplexer acknowledges the last beat of the granted packet.

Parameters:
NUM_STREAMS, 4, number of input streams arbitrated; legal range 2..256.
MAX_BURST, 1, packets a stream may send back-to-back before priority moves on; legal range 1..255.
SEL_W, $clog2(NUM_STREAMS), width of select_data (derived, not overridable).

Ports:
clk  in  1  clock; all state is updated on the rising edge.
rst  in  1  asynchronous active-high reset.
enable  in  1  when low, no new grant is issued; an active grant still completes.
req_valid  in  NUM_STREAMS  valid line of each input stream; bit i is stream i.
select_valid  out  1  a select token is presented.
select_data  out  SEL_W  index of the granted stream.
select_ready  in  1  the multiplexer consumed the token; pulses on the last-beat handshake of the granted packet.
busy  out  1  high while in the GRANT state.
burst_cnt  out  8  packets completed under the current grantee since the grant moved to it.

Behaviour:
Reset (async assert, sync to clk on release):
- state = IDLE, select_valid = 0, select_data = 0, busy = 0, burst_cnt = 0, ptr = 0, last_grant = 0.

States:
IDLE
- select_valid = 0.
- If enable && |req_valid: winner = first i with req_valid[i] = 1, scanning ptr, ptr+1, …, NUM_STREAMS-1, 0, …, ptr-1 (modulo wrap).
- On that edge: select_data <= winner, select_valid <= 1, state <= GRANT.
- If winner != last_grant: burst_cnt <= 0. last_grant <= winner.
- Latency: req_valid seen in cycle N gives select_valid = 1 in cycle N+1.
- Otherwise stay in IDLE with all outputs unchanged.

GRANT
- select_valid = 1; select_data is held constant for the whole state.
- req_valid is ignored here, including deassertion by the grantee mid-packet.
- On a cycle with select_valid && select_ready:
  - burst_cnt <= burst_cnt + 1 (saturating at 255).
  - If burst_cnt + 1 < MAX_BURST: ptr <= select_data, so the same stream keeps priority.
  - Else: ptr <= (select_data + 1) mod NUM_STREAMS, and burst_cnt <= 0.
  - select_valid <= 0, state <= IDLE.

Timing and ordering:
- There is one mandatory bubble cycle in IDLE between consecutive grants. Packet-to-packet overhead is exactly 1 cycle.
- select_ready while in IDLE (select_valid = 0) is ignored and changes no state.
- enable falling during GRANT does not abort the grant; the next grant is blocked in IDLE until enable = 1.
- ptr wraps from NUM_STREAMS-1 to 0.
- burst_cnt is reset to 0 when the grant moves to a different stream, or when MAX_BURST is reached.
- busy = (state == GRANT).
- Reset asserted mid-GRANT: select_valid drops to 0 immediately (async). The downstream packet is abandoned; the downstream stage is reset in the same domain.
- No combinational path exists from any input to any output; all outputs come directly from registers.

Test Plan:
- Reset and idle: hold rst high, then release with req_valid = 0 -> select_valid = 0, select_data = 0, busy = 0 for 10 cycles.
- Rotating order: NUM_STREAMS = 4, MAX_BURST = 1, req_valid = 4'b1111 held, select_ready pulsed 3 cycles after each grant -> select_data sequence 0,1,2,3,0 with exactly one select_valid = 0 cycle between grants.
- Burst: MAX_BURST = 3, req_valid = 4'b0101, ready pulsed per grant -> select_data sequence 0,0,0,2,2,2,0; burst_cnt shows 1,2 then 0 when the burst limit is reached.
- Skip and wrap: ptr = 3 after granting stream 2, req_valid = 4'b0010 -> grant 1 (scan 3,0,1), then ptr = 2.
- Hold stability: during GRANT, toggle req_valid randomly and hold select_ready = 0 for 20 cycles -> select_data and select_valid are unchanged, busy = 1.
- Enable and reset: enable = 0 with req_valid = 4'b1000 -> no grant; raise enable -> select_valid = 1 one cycle later with select_data = 3; assert rst mid-grant -> select_valid = 0 in the same cycle and ptr = 0 after release.

Source files
------------

// File: rtl/stream_select_arbiter.sv
// Select-token generator for the data multiplexer stage.
// Rotating-priority grant with a bounded packet burst per grantee.
module stream_select_arbiter #(
  parameter  int NUM_STREAMS = 4,
  parameter  int MAX_BURST   = 1,
  localparam int SEL_W       = $clog2(NUM_STREAMS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_STREAMS-1:0] req_valid,
  output logic                   select_valid,
  output logic [SEL_W-1:0]       select_data,
  input  logic                   select_ready,
  output logic                   busy,
  output logic [7:0]             burst_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [SEL_W:0]   N_W   = (SEL_W+1)'(NUM_STREAMS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_STREAMS - 1);
  localparam logic [8:0]       BURST = 9'(MAX_BURST);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] idx;
  logic [SEL_W:0]   sum;
  logic             found;
  logic [8:0]       cnt_inc;
  logic [7:0]       cnt_sat;
  logic [SEL_W-1:0] ptr_next;

  // First requester at or after ptr, wrapping modulo NUM_STREAMS
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (sum >= N_W)
        sum = sum - N_W;
      idx = sum[SEL_W-1:0];
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign cnt_inc  = {1'b0, burst_cnt} + 9'd1;
  assign cnt_sat  = cnt_inc[8] ? 8'hff : cnt_inc[7:0];
  assign ptr_next = (select_data == LAST) ? '0 : select_data + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      select_valid <= 1'b0;
      select_data  <= '0;
      busy         <= 1'b0;
      burst_cnt    <= '0;
      ptr          <= '0;
      last_grant   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && found) begin
            select_data  <= winner;
            select_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= GRANT;
            last_grant   <= winner;
            if (winner != last_grant)
              burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (select_ready) begin
            select_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
            if (cnt_inc < BURST) begin
              ptr       <= select_data;
              burst_cnt <= cnt_sat;
            end else begin
              ptr       <= ptr_next;
              burst_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_select_arbiter.sv
// Directed bench for stream_select_arbiter: two instances,
// MAX_BURST=1 (rotation, skip, hold, enable, reset) and MAX_BURST=3.
module tb_stream_select_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, b_en;
  logic [3:0] a_req, b_req;
  logic       a_ready, b_ready;
  logic       a_valid, b_valid;
  logic [1:0] a_data, b_data;
  logic       a_busy, b_busy;
  logic [7:0] a_burst, b_burst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_select_arbiter #(.NUM_STREAMS(4), .MAX_BURST(1)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .enable       (a_en),
    .req_valid    (a_req),
    .select_valid (a_valid),
    .select_data  (a_data),
    .select_ready (a_ready),
    .busy         (a_busy),
    .burst_cnt    (a_burst)
  );

  stream_select_arbiter #(.NUM_STREAMS(4), .MAX_BURST(3)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .enable       (b_en),
    .req_valid    (b_req),
    .select_valid (b_valid),
    .select_data  (b_data),
    .select_ready (b_ready),
    .busy         (b_busy),
    .burst_cnt    (b_burst)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Wait for a grant, check gap and index, then ack 3 cycles later.
  task automatic serve(input bit use_b, input string tag,
                       input int exp_data, input int exp_gap);
    int gap = 0;
    while (!(use_b ? b_valid : a_valid) && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk({tag, "_gap"}, gap, exp_gap);
    chk({tag, "_data"}, int'(use_b ? b_data : a_data), exp_data);
    repeat (2) @(negedge clk);
    if (use_b) b_ready = 1'b1; else a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    b_ready = 1'b0;
  endtask

  initial begin
    int rot_exp [5] = '{0, 1, 2, 3, 0};
    int bst_exp [7] = '{0, 0, 0, 2, 2, 2, 0};
    int bcnt_exp[7] = '{1, 2, 0, 1, 2, 0, 1};

    rst = 1'b1; a_en = 1'b1; b_en = 1'b1;
    a_req = '0; b_req = '0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_a", int'({a_valid, a_data, a_busy}), 0);
      chk("idle_b", int'({b_valid, b_data, b_busy}), 0);
    end

    a_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(1'b0, $sformatf("rot%0d", i), rot_exp[i], 1);
      chk("rot_burst", int'(a_burst), 0);
    end
    a_req = 4'b0000;
    @(negedge clk);

    // ptr=1 here: grant 2 leaves ptr=3, then 0010 scans 3,0,1
    a_req = 4'b0100;
    serve(1'b0, "skip2", 2, 1);
    a_req = 4'b0010;
    serve(1'b0, "wrap1", 1, 1);
    a_req = 4'b1111;
    serve(1'b0, "ptr2", 2, 1);
    a_req = 4'b1111;

    // ptr=3: grant 3 and hold it under random req noise
    begin
      int gap = 0;
      while (!a_valid && gap < 20) begin
        @(negedge clk);
        gap++;
      end
      chk("hold_gap", gap, 1);
      for (int i = 0; i < 20; i++) begin
        a_req = 4'($urandom);
        @(negedge clk);
        chk("hold", int'({a_valid, a_busy, a_data}), 'b1111);
      end
      a_req = 4'b0000;
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
      chk("hold_rel", int'({a_valid, a_busy}), 0);
    end

    b_req = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      serve(1'b1, $sformatf("bst%0d", i), bst_exp[i], 1);
      chk($sformatf("bcnt%0d", i), int'(b_burst), bcnt_exp[i]);
    end
    b_req = 4'b0000;

    // ptr=0 after wrap; enable low blocks, idle ready ignored
    a_en = 1'b0;
    a_req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      a_ready = (i == 2);
      @(negedge clk);
      chk("en_off", int'({a_valid, a_busy}), 0);
    end
    a_ready = 1'b0;
    a_en = 1'b1;
    @(negedge clk);
    chk("en_on", int'({a_valid, a_data}), 'b111);

    #2 rst = 1'b1;
    #1 chk("rst_async", int'({a_valid, a_busy}), 0);
    @(negedge clk);
    rst = 1'b0;
    a_req = 4'b1111;
    serve(1'b0, "post_rst", 0, 1);
    a_req = 4'b0000;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
